// File: rtl/ccip_rpc_transmitter.sv
// NIC-to-CPU RPC transmitter: one CCI-P c1 WRLINE per RPC into per-flow rings.
// Optional flow-id range check: define CCIP_TX_FLOW_CHECK_EN.
package ccip_rpc_pkg;
  localparam int LMAX_CCIP_BATCH = 4;

  typedef logic [41:0] t_ccip_clAddr;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic       valid;
    logic       update_flag;
    logic [5:0] rsvd;
  } RpcCtl;

  typedef struct packed {
    RpcCtl       ctl;
    logic [7:0]  num_of_args;
    logic [15:0] fn_id;
    logic [31:0] rpc_id;
  } RpcHdr;

  typedef struct packed {
    RpcHdr       hdr;
    logic [63:0] argv;
  } RpcPckt;

  typedef struct packed {
    RpcPckt rpc_data;
  } RpcIf;
endpackage

module single_clock_wr_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADR_WIDTH];

  // Read-during-write to one address returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

module ccip_rpc_transmitter
  import ccip_rpc_pkg::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  t_ccip_clAddr                 tx_base_addr,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
  input  logic                         start,
  input  logic                         initialize,
  output logic                         initialized,
  output logic                         error,
  input  logic                         sRx_c1TxAlmFull,
  output t_if_ccip_c1_Tx               sTx_c1,
  input  logic                         lb_select,
  output logic                         ccip_tx_ready,
  input  RpcIf                         rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  output logic                         pdrop_tx_flows_out
);
  localparam int unused_nic_id = NIC_ID;

  typedef logic [LMAX_NUM_OF_FLOWS-1:0] flow_t;

  typedef struct packed {
    logic                       parity;
    logic [LMAX_CCIP_BATCH-1:0] slot;
  } ptr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } init_st_t;

  init_st_t       st_q;
  flow_t          clr_addr_q;
  logic           initialized_q;
  logic           ready_q;
  logic           pdrop_q;
  logic           error_q;
  logic           s1_valid_q;
  flow_t          s1_flow_q;
  RpcPckt         s1_data_q;
  t_ccip_vc       s1_vc_q;
  logic           fwd_valid_q;
  flow_t          fwd_flow_q;
  ptr_t           fwd_ptr_q;
  t_if_ccip_c1_Tx tx_q;

  logic               flow_bad;
  logic               accept;
  logic               drop;
  ptr_t               ram_rdata;
  ptr_t               ptr_cur;
  ptr_t               ptr_nxt;
  logic               ram_we;
  flow_t              ram_waddr;
  ptr_t               ram_wdata;
  logic [LMAX_CCIP_BATCH-1:0] slot_max;
  RpcPckt             line_rpc;
  t_ccip_c1_ReqMemHdr line_hdr;

`ifdef CCIP_TX_FLOW_CHECK_EN
  assign flow_bad = rpc_flow_id_in > number_of_flows;
`else
  logic unused_nof;
  assign unused_nof = ^number_of_flows;
  assign flow_bad   = 1'b0;
`endif

  assign accept = rpc_in_valid & ready_q & ~flow_bad;
  assign drop   = rpc_in_valid & (~ready_q | flow_bad);

  single_clock_wr_ram #(
    .DATA_WIDTH(LMAX_CCIP_BATCH + 1),
    .ADR_WIDTH (LMAX_NUM_OF_FLOWS)
  ) u_ptr_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(rpc_flow_id_in),
    .rdata(ram_rdata)
  );

  assign slot_max =
    LMAX_CCIP_BATCH'((32'd1 << l_tx_batch_size) - 32'd1);

  // The previous cycle's write-back is not yet visible in the RAM read.
  always_comb begin
    ptr_cur = ram_rdata;
    if (fwd_valid_q && fwd_flow_q == s1_flow_q) ptr_cur = fwd_ptr_q;
    ptr_nxt = ptr_cur;
    if (ptr_cur.slot == slot_max) begin
      ptr_nxt.slot   = '0;
      ptr_nxt.parity = ~ptr_cur.parity;
    end else begin
      ptr_nxt.slot = ptr_cur.slot + 1'b1;
    end
  end

  always_comb begin
    ram_we    = s1_valid_q;
    ram_waddr = s1_flow_q;
    ram_wdata = ptr_nxt;
    if (st_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end
  end

  always_comb begin
    line_rpc = s1_data_q;
    line_rpc.hdr.ctl.update_flag = ~ptr_cur.parity;
    line_hdr          = '0;
    line_hdr.vc_sel   = s1_vc_q;
    line_hdr.sop      = 1'b1;
    line_hdr.cl_len   = eCL_LEN_1;
    line_hdr.req_type = eREQ_WRLINE_I;
    line_hdr.address  = tx_base_addr
                      + (t_ccip_clAddr'(s1_flow_q) << l_tx_batch_size)
                      + t_ccip_clAddr'(ptr_cur.slot);
    line_hdr.mdata    = 16'(s1_flow_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q          <= ST_IDLE;
      clr_addr_q    <= '0;
      initialized_q <= 1'b0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (initialize && !initialized_q) begin
            st_q       <= ST_CLEAR;
            clr_addr_q <= '0;
          end
        end
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            st_q          <= ST_DONE;
            initialized_q <= 1'b1;
          end
        end
        ST_DONE: st_q <= ST_DONE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q     <= 1'b0;
      pdrop_q     <= 1'b0;
      error_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_flow_q   <= '0;
      s1_data_q   <= '0;
      s1_vc_q     <= eVC_VA;
      fwd_valid_q <= 1'b0;
      fwd_flow_q  <= '0;
      fwd_ptr_q   <= '0;
      tx_q        <= '0;
    end else begin
      ready_q <= initialized_q & start & ~sRx_c1TxAlmFull;
      pdrop_q <= drop;
      if (rpc_in_valid & ready_q & flow_bad) error_q <= 1'b1;
      s1_valid_q <= accept;
      if (accept) begin
        s1_flow_q <= rpc_flow_id_in;
        s1_data_q <= rpc_in.rpc_data;
        s1_vc_q   <= lb_select ? eVC_VA : eVC_VH0;
      end
      fwd_valid_q <= s1_valid_q;
      fwd_flow_q  <= s1_flow_q;
      fwd_ptr_q   <= ptr_nxt;
      tx_q.valid  <= s1_valid_q;
      if (s1_valid_q) begin
        tx_q.hdr  <= line_hdr;
        tx_q.data <= {{(512 - $bits(RpcPckt)){1'b0}}, line_rpc};
      end
    end
  end

  assign sTx_c1             = tx_q;
  assign initialized        = initialized_q;
  assign error              = error_q;
  assign ccip_tx_ready      = ready_q;
  assign pdrop_tx_flows_out = pdrop_q;
endmodule

// File: tb/tb_ccip_rpc_transmitter.sv
// Randomized self-checking bench for ccip_rpc_transmitter.
// Expected lines come from a per-flow RPC counter model of the ring buffers.
`timescale 1ns/1ps
module tb_ccip_rpc_transmitter;
  import ccip_rpc_pkg::*;

  localparam int LF = 2;
  localparam int NF = 1 << LF;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [LF-1:0]              number_of_flows = 2'd3;
  t_ccip_clAddr               tx_base_addr = '0;
  logic [LMAX_CCIP_BATCH-1:0] l_tx_batch_size = 4'd2;
  logic                       start = 1'b0;
  logic                       initialize = 1'b0;
  logic                       initialized;
  logic                       error;
  logic                       sRx_c1TxAlmFull = 1'b0;
  t_if_ccip_c1_Tx             sTx_c1;
  logic                       lb_select = 1'b0;
  logic                       ccip_tx_ready;
  RpcIf                       rpc_in = '0;
  logic                       rpc_in_valid = 1'b0;
  logic [LF-1:0]              rpc_flow_id_in = '0;
  logic                       pdrop_tx_flows_out;

  int cmp_n = 0;
  int err_n = 0;
  int cyc = 0;
  int drop_cnt = 0;
  t_if_ccip_c1_Tx obs_q[$];
  int             obs_cyc[$];
  t_if_ccip_c1_Tx exp_q[$];
  int unsigned    cnt[NF];

  ccip_rpc_transmitter #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF)) dut (
    .clk(clk), .reset(reset), .number_of_flows(number_of_flows),
    .tx_base_addr(tx_base_addr), .l_tx_batch_size(l_tx_batch_size),
    .start(start), .initialize(initialize), .initialized(initialized),
    .error(error), .sRx_c1TxAlmFull(sRx_c1TxAlmFull), .sTx_c1(sTx_c1),
    .lb_select(lb_select), .ccip_tx_ready(ccip_tx_ready), .rpc_in(rpc_in),
    .rpc_in_valid(rpc_in_valid), .rpc_flow_id_in(rpc_flow_id_in),
    .pdrop_tx_flows_out(pdrop_tx_flows_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sTx_c1.valid) begin
      obs_q.push_back(sTx_c1);
      obs_cyc.push_back(cyc);
    end
    if (pdrop_tx_flows_out) drop_cnt++;
  end

  // Ring model: the n-th RPC of a flow lands in slot n mod S, lap parity n/S.
  function automatic t_if_ccip_c1_Tx model_line(int f, RpcPckt p, logic lb);
    t_if_ccip_c1_Tx e;
    int unsigned slots, slot;
    logic par;
    slots = 1 << l_tx_batch_size;
    slot  = cnt[f] % slots;
    par   = ((cnt[f] / slots) % 2) != 0;
    cnt[f]++;
    e = '0;
    e.valid = 1'b1;
    e.hdr.vc_sel = lb ? eVC_VA : eVC_VH0;
    e.hdr.sop = 1'b1;
    e.hdr.cl_len = eCL_LEN_1;
    e.hdr.req_type = eREQ_WRLINE_I;
    e.hdr.address = tx_base_addr + t_ccip_clAddr'(f * slots + slot);
    e.hdr.mdata = 16'(f);
    p.hdr.ctl.update_flag = ~par;
    e.data = {384'b0, p};
    return e;
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(int f, logic lb, output RpcPckt p);
    p = RpcPckt'({$urandom(), $urandom(), $urandom(), $urandom()});
    rpc_in.rpc_data = p;
    rpc_flow_id_in = f[LF-1:0];
    lb_select = lb;
    rpc_in_valid = 1'b1;
    tick(1);
    rpc_in_valid = 1'b0;
  endtask

  task automatic settle();
    tick(6);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    cmp_n += 6;
    if (sTx_c1.valid !== 1'b0) begin err_n++; $display("FAIL reset_valid: got %b want 0", sTx_c1.valid); end
    if (sTx_c1.hdr !== '0) begin err_n++; $display("FAIL reset_hdr: got %h want 0", sTx_c1.hdr); end
    if (initialized !== 1'b0) begin err_n++; $display("FAIL reset_init: got %b want 0", initialized); end
    if (error !== 1'b0) begin err_n++; $display("FAIL reset_error: got %b want 0", error); end
    if (ccip_tx_ready !== 1'b0) begin err_n++; $display("FAIL reset_ready: got %b want 0", ccip_tx_ready); end
    if (pdrop_tx_flows_out !== 1'b0) begin err_n++; $display("FAIL reset_pdrop: got %b want 0", pdrop_tx_flows_out); end
    reset = 1'b1;
    tick(2);
    cmp_n++;
    if (initialized !== 1'b0) begin err_n++; $display("FAIL post_reset_init: got %b want 0", initialized); end
  endtask

  task automatic test_init();
    int c0, k;
    foreach (cnt[i]) cnt[i] = 0;
    initialize = 1'b1;
    c0 = cyc;
    tick(1);
    initialize = 1'b0;
    for (k = 0; k < 20 && initialized !== 1'b1; k++) tick(1);
    cmp_n += 3;
    if (initialized !== 1'b1) begin err_n++; $display("FAIL init_done: got %b want 1", initialized); end
    if (cyc - c0 !== 5) begin err_n++; $display("FAIL init_latency: got %0d want 5", cyc - c0); end
    if (ccip_tx_ready !== 1'b0) begin err_n++; $display("FAIL ready_no_start: got %b want 0", ccip_tx_ready); end
    start = 1'b1;
    tick(1);
    cmp_n++;
    if (ccip_tx_ready !== 1'b1) begin err_n++; $display("FAIL ready_start: got %b want 1", ccip_tx_ready); end
  endtask

  task automatic test_single_write();
    RpcPckt p, r;
    t_if_ccip_c1_Tx e;
    int c0;
    logic lb;
    tx_base_addr = 42'h1000;
    l_tx_batch_size = 4'd2;
    settle();
    lb = 1'($urandom_range(1, 0));
    c0 = cyc;
    issue(1, lb, p);
    e = model_line(1, p, lb);
    tick(6);
    cmp_n++;
    if (obs_q.size() !== 1) begin
      err_n++; $display("FAIL single_count: got %0d want 1", obs_q.size());
    end else begin
      r = RpcPckt'(obs_q[0].data[127:0]);
      cmp_n += 6;
      if (obs_cyc[0] - c0 !== 2) begin err_n++; $display("FAIL single_latency: got %0d want 2", obs_cyc[0] - c0); end
      if (obs_q[0].hdr.address !== 42'h1004) begin err_n++; $display("FAIL single_addr: got %h want 1004", obs_q[0].hdr.address); end
      if (r.hdr.ctl.update_flag !== 1'b1) begin err_n++; $display("FAIL single_flag: got %b want 1", r.hdr.ctl.update_flag); end
      if (obs_q[0].hdr.mdata !== 16'd1) begin err_n++; $display("FAIL single_mdata: got %h want 1", obs_q[0].hdr.mdata); end
      if (obs_q[0].hdr !== e.hdr) begin err_n++; $display("FAIL single_hdr: got %h want %h", obs_q[0].hdr, e.hdr); end
      if (obs_q[0].data !== e.data) begin err_n++; $display("FAIL single_data: got %h want %h", obs_q[0].data, e.data); end
    end
  endtask

  task automatic test_wrap();
    RpcPckt p, r;
    int off[5] = '{0, 1, 2, 3, 0};
    logic flg[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    settle();
    for (int i = 0; i < 5; i++) begin
      issue(0, 1'b0, p);
      exp_q.push_back(model_line(0, p, 1'b0));
    end
    tick(6);
    cmp_n++;
    if (obs_q.size() !== 5) begin err_n++; $display("FAIL wrap_count: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      r = RpcPckt'(obs_q[i].data[127:0]);
      cmp_n += 3;
      if (obs_q[i].hdr.address - tx_base_addr !== 42'(off[i])) begin
        err_n++; $display("FAIL wrap_off[%0d]: got %0d want %0d", i, obs_q[i].hdr.address - tx_base_addr, off[i]);
      end
      if (r.hdr.ctl.update_flag !== flg[i]) begin
        err_n++; $display("FAIL wrap_flag[%0d]: got %b want %b", i, r.hdr.ctl.update_flag, flg[i]);
      end
      if (obs_q[i] !== exp_q[i]) begin
        err_n++; $display("FAIL wrap_line[%0d]: got %h want %h", i, obs_q[i].hdr, exp_q[i].hdr);
      end
    end
  endtask

  task automatic test_back_to_back();
    RpcPckt p;
    settle();
    for (int i = 0; i < 3; i++) begin
      issue(2, 1'b1, p);
      exp_q.push_back(model_line(2, p, 1'b1));
    end
    tick(6);
    cmp_n++;
    if (obs_q.size() !== 3) begin err_n++; $display("FAIL b2b_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      cmp_n += 2;
      if (obs_q[i].hdr.address !== tx_base_addr + 42'(8 + i)) begin
        err_n++; $display("FAIL b2b_slot[%0d]: got %h want %h", i, obs_q[i].hdr.address, tx_base_addr + 42'(8 + i));
      end
      if (obs_q[i] !== exp_q[i]) begin
        err_n++; $display("FAIL b2b_line[%0d]: got %h want %h", i, obs_q[i].hdr, exp_q[i].hdr);
      end
    end
  endtask

  task automatic test_random();
    RpcPckt p;
    int f;
    logic lb;
    tx_base_addr = t_ccip_clAddr'({$urandom(), $urandom()});
    settle();
    for (int i = 0; i < 60; i++) begin
      f = int'($urandom_range(NF - 1, 0));
      lb = 1'($urandom_range(1, 0));
      issue(f, lb, p);
      exp_q.push_back(model_line(f, p, lb));
      tick(int'($urandom_range(2, 0)));
    end
    tick(6);
    cmp_n++;
    if (obs_q.size() !== exp_q.size()) begin
      err_n++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      cmp_n++;
      if (obs_q[i] !== exp_q[i]) begin
        err_n++;
        $display("FAIL random_line[%0d]: got hdr %h data %h want hdr %h data %h", i, obs_q[i].hdr, obs_q[i].data[127:0], exp_q[i].hdr, exp_q[i].data[127:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    RpcPckt p;
    int d0, f;
    settle();
    d0 = drop_cnt;
    f = int'($urandom_range(NF - 1, 0));
    sRx_c1TxAlmFull = 1'b1;
    issue(f, 1'b0, p);
    exp_q.push_back(model_line(f, p, 1'b0));
    for (int i = 0; i < 4; i++) issue(int'($urandom_range(NF - 1, 0)), 1'b1, p);
    cmp_n++;
    if (ccip_tx_ready !== 1'b0) begin err_n++; $display("FAIL bp_ready: got %b want 0", ccip_tx_ready); end
    tick(6);
    cmp_n += 3;
    if (obs_q.size() !== 1) begin err_n++; $display("FAIL bp_count: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== exp_q[0]) begin err_n++; $display("FAIL bp_line: got %h want %h", obs_q[0].hdr, exp_q[0].hdr); end
    if (drop_cnt - d0 !== 4) begin err_n++; $display("FAIL bp_drops: got %0d want 4", drop_cnt - d0); end
    if (error !== 1'b0) begin err_n++; $display("FAIL bp_error: got %b want 0", error); end
    sRx_c1TxAlmFull = 1'b0;
    tick(2);
    cmp_n++;
    if (ccip_tx_ready !== 1'b1) begin err_n++; $display("FAIL bp_recover: got %b want 1", ccip_tx_ready); end
  endtask

  task automatic test_flow_check();
    RpcPckt p;
    int d0;
    settle();
    number_of_flows = 2'd1;
    d0 = drop_cnt;
    issue(3, 1'b0, p);
`ifdef CCIP_TX_FLOW_CHECK_EN
    tick(6);
    cmp_n += 3;
    if (obs_q.size() !== 0) begin err_n++; $display("FAIL fc_count: got %0d want 0", obs_q.size()); end
    if (drop_cnt - d0 !== 1) begin err_n++; $display("FAIL fc_drop: got %0d want 1", drop_cnt - d0); end
    if (error !== 1'b1) begin err_n++; $display("FAIL fc_error: got %b want 1", error); end
    issue(1, 1'b0, p);
    exp_q.push_back(model_line(1, p, 1'b0));
    tick(10);
    cmp_n += 2;
    if (error !== 1'b1) begin err_n++; $display("FAIL fc_sticky: got %b want 1", error); end
    if (obs_q.size() !== 1) begin err_n++; $display("FAIL fc_ok_count: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== exp_q[0]) begin err_n++; $display("FAIL fc_ok_line: got %h want %h", obs_q[0].hdr, exp_q[0].hdr); end
`else
    exp_q.push_back(model_line(3, p, 1'b0));
    tick(6);
    cmp_n += 3;
    if (obs_q.size() !== 1) begin err_n++; $display("FAIL fc_count: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== exp_q[0]) begin err_n++; $display("FAIL fc_line: got %h want %h", obs_q[0].hdr, exp_q[0].hdr); end
    if (drop_cnt - d0 !== 0) begin err_n++; $display("FAIL fc_drop: got %0d want 0", drop_cnt - d0); end
    if (error !== 1'b0) begin err_n++; $display("FAIL fc_error: got %b want 0", error); end
`endif
    number_of_flows = 2'd3;
  endtask

  task automatic test_reset_midop();
    RpcPckt p;
    t_if_ccip_c1_Tx e;
    int k;
    settle();
    issue(2, 1'b0, p);
    issue(2, 1'b1, p);
    reset = 1'b0;
    #1;
    cmp_n += 4;
    if (sTx_c1.valid !== 1'b0) begin err_n++; $display("FAIL mid_valid: got %b want 0", sTx_c1.valid); end
    if (ccip_tx_ready !== 1'b0) begin err_n++; $display("FAIL mid_ready: got %b want 0", ccip_tx_ready); end
    if (initialized !== 1'b0) begin err_n++; $display("FAIL mid_init: got %b want 0", initialized); end
    if (error !== 1'b0) begin err_n++; $display("FAIL mid_error: got %b want 0", error); end
    tick(2);
    reset = 1'b1;
    tick(6);
    cmp_n += 2;
    if (obs_q.size() !== 0) begin err_n++; $display("FAIL mid_squash: got %0d want 0", obs_q.size()); end
    if (ccip_tx_ready !== 1'b0) begin err_n++; $display("FAIL mid_noinit_ready: got %b want 0", ccip_tx_ready); end
    foreach (cnt[i]) cnt[i] = 0;
    initialize = 1'b1;
    tick(1);
    initialize = 1'b0;
    for (k = 0; k < 20 && initialized !== 1'b1; k++) tick(1);
    tick(1);
    cmp_n++;
    if (ccip_tx_ready !== 1'b1) begin err_n++; $display("FAIL reinit_ready: got %b want 1", ccip_tx_ready); end
    issue(2, 1'b0, p);
    e = model_line(2, p, 1'b0);
    tick(6);
    cmp_n++;
    if (obs_q.size() !== 1) begin err_n++; $display("FAIL reinit_count: got %0d want 1", obs_q.size()); end
    else begin
      cmp_n++;
      if (obs_q[0] !== e) begin err_n++; $display("FAIL reinit_line: got %h want %h", obs_q[0].hdr, e.hdr); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_wrap();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_flow_check();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
